// File: rtl/hamming_sched_if.sv
// rtl/hamming_sched_if.sv - request/response bundle for the Hamming(7,4) scheduler
//
// Purpose: groups the two requester channels and the result channel.
// Ports (slave = scheduler side):
//   rq0_valid/op/payload, rq1_valid/op/payload : requester jobs (in to slave)
//   rq0_ready, rq1_ready                        : job accepted this cycle (out of slave)
//   rsp_valid/src/op/code/data/syndrome/err     : registered result (out of slave)
//   rsp_ready                                   : consumer accepts result (in to slave)
interface hamming_sched_if;
    logic       rq0_valid;
    logic       rq0_ready;
    logic       rq0_op;
    logic [6:0] rq0_payload;
    logic       rq1_valid;
    logic       rq1_ready;
    logic       rq1_op;
    logic [6:0] rq1_payload;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_src;
    logic       rsp_op;
    logic [6:0] rsp_code;
    logic [3:0] rsp_data;
    logic [2:0] rsp_syndrome;
    logic       rsp_err;

    modport master (
        output rq0_valid, rq0_op, rq0_payload,
        output rq1_valid, rq1_op, rq1_payload,
        output rsp_ready,
        input  rq0_ready, rq1_ready,
        input  rsp_valid, rsp_src, rsp_op, rsp_code, rsp_data, rsp_syndrome, rsp_err
    );

    modport slave (
        input  rq0_valid, rq0_op, rq0_payload,
        input  rq1_valid, rq1_op, rq1_payload,
        input  rsp_ready,
        output rq0_ready, rq1_ready,
        output rsp_valid, rsp_src, rsp_op, rsp_code, rsp_data, rsp_syndrome, rsp_err
    );
endinterface

// File: rtl/hamming_sched.sv
// rtl/hamming_sched.sv - two-requester round-robin scheduler over one Hamming(7,4) encode/check path
//
// Purpose: arbitrates encode/check jobs from two requesters into a single
// registered result stage and counts corrected errors.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : hamming_sched_if.slave (requests in, results out)
//   cnt_clr  : synchronous clear of corr_cnt (wins over increment)
//   corr_cnt : saturating count of accepted check jobs with nonzero syndrome
module hamming_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hamming_sched_if.slave   bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt
);

    logic             prio_q, prio_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_src_q, rsp_src_d;
    logic             rsp_op_q, rsp_op_d;
    logic [6:0]       rsp_code_q, rsp_code_d;
    logic [3:0]       rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_syn_q, rsp_syn_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       slot_free;
    logic       grant0, grant1;
    logic       ready0, ready1;
    logic       accept, sel;
    logic       sel_op;
    logic [6:0] sel_pl;
    logic [3:0] enc_d;
    logic [6:0] enc_code;
    logic [2:0] syn;
    logic [2:0] flip_idx;
    logic [6:0] fixed_code;

    always_comb begin
        slot_free = !rsp_valid_q || bus.rsp_ready;
        // Preferred requester wins only when both ask; a lone requester always wins.
        grant0 = bus.rq0_valid && (!bus.rq1_valid || !prio_q);
        grant1 = bus.rq1_valid && (!bus.rq0_valid ||  prio_q);
        // Gate with rst_n so no handshake can complete while reset is held.
        ready0 = rst_n && grant0 && slot_free;
        ready1 = rst_n && grant1 && slot_free;
        accept = ready0 || ready1;
        sel    = ready1;
        sel_op = sel ? bus.rq1_op      : bus.rq0_op;
        sel_pl = sel ? bus.rq1_payload : bus.rq0_payload;

        enc_d       = sel_pl[3:0];
        enc_code    = 7'd0;
        enc_code[0] = enc_d[3];
        enc_code[1] = enc_d[2];
        enc_code[2] = enc_d[1];
        enc_code[4] = enc_d[0];
        enc_code[6] = enc_d[3] ^ enc_d[1] ^ enc_d[0];
        enc_code[5] = enc_d[3] ^ enc_d[2] ^ enc_d[0];
        enc_code[3] = enc_d[3] ^ enc_d[2] ^ enc_d[1];

        syn[0] = sel_pl[0] ^ sel_pl[2] ^ sel_pl[4] ^ sel_pl[6];
        syn[1] = sel_pl[0] ^ sel_pl[1] ^ sel_pl[4] ^ sel_pl[5];
        syn[2] = sel_pl[0] ^ sel_pl[1] ^ sel_pl[2] ^ sel_pl[3];
        // Syndrome S points at bit 7-S; every nonzero S is taken as a single-bit error.
        flip_idx   = 3'd7 - syn;
        fixed_code = (syn != 3'd0) ? (sel_pl ^ (7'd1 << flip_idx)) : sel_pl;
    end

    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = rsp_valid_q;
        rsp_src_d   = rsp_src_q;
        rsp_op_d    = rsp_op_q;
        rsp_code_d  = rsp_code_q;
        rsp_data_d  = rsp_data_q;
        rsp_syn_d   = rsp_syn_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        if (accept) begin
            prio_d      = ~sel;
            rsp_valid_d = 1'b1;
            rsp_src_d   = sel;
            rsp_op_d    = sel_op;
            if (sel_op) begin
                rsp_code_d = fixed_code;
                rsp_data_d = {fixed_code[0], fixed_code[1], fixed_code[2], fixed_code[4]};
                rsp_syn_d  = syn;
                rsp_err_d  = (syn != 3'd0);
            end else begin
                rsp_code_d = enc_code;
                rsp_data_d = enc_d;
                rsp_syn_d  = 3'd0;
                rsp_err_d  = 1'b0;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && sel_op && (syn != 3'd0) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            rsp_op_q    <= 1'b0;
            rsp_code_q  <= 7'd0;
            rsp_data_q  <= 4'd0;
            rsp_syn_q   <= 3'd0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_op_q    <= rsp_op_d;
            rsp_code_q  <= rsp_code_d;
            rsp_data_q  <= rsp_data_d;
            rsp_syn_q   <= rsp_syn_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.rq0_ready    = ready0;
    assign bus.rq1_ready    = ready1;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_src      = rsp_src_q;
    assign bus.rsp_op       = rsp_op_q;
    assign bus.rsp_code     = rsp_code_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_syndrome = rsp_syn_q;
    assign bus.rsp_err      = rsp_err_q;
    assign corr_cnt         = cnt_q;

endmodule

// File: tb/tb_hamming_sched.sv
// tb/tb_hamming_sched.sv - self-checking bench for hamming_sched
module tb_hamming_sched;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] corr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_sched_if bus ();

    hamming_sched #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .cnt_clr  (cnt_clr),
        .corr_cnt (corr_cnt)
    );

    // Reference model state
    bit         m_prio;
    bit         m_valid;
    bit         m_src;
    bit         m_op;
    logic [6:0] m_code;
    logic [3:0] m_data;
    logic [2:0] m_syn;
    bit         m_err;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[3];
        c[1] = d[2];
        c[2] = d[1];
        c[4] = d[0];
        c[6] = d[3] ^ d[1] ^ d[0];
        c[5] = d[3] ^ d[2] ^ d[0];
        c[3] = d[3] ^ d[2] ^ d[1];
        return c;
    endfunction

    // Nearest-codeword search: the code is perfect, so exactly one codeword is within distance 1.
    task automatic decode(input logic [6:0] r, output logic [6:0] cw, output logic [3:0] d,
                          output logic [2:0] s);
        logic [6:0] x;
        logic [3:0] kd;
        cw = 7'd0;
        d  = 4'd0;
        s  = 3'd0;
        for (int k = 0; k < 16; k++) begin
            kd = k[3:0];
            x  = r ^ enc(kd);
            if ($countones(x) <= 1) begin
                cw = enc(kd);
                d  = kd;
                for (int i = 0; i < 7; i++)
                    if (x[i]) s = 3'(7 - i);
            end
        end
    endtask

    task automatic drive(input bit v0, input bit op0, input logic [6:0] p0,
                         input bit v1, input bit op1, input logic [6:0] p1,
                         input bit rdy, input bit clr);
        bus.rq0_valid   = v0;
        bus.rq0_op      = op0;
        bus.rq0_payload = p0;
        bus.rq1_valid   = v1;
        bus.rq1_op      = op1;
        bus.rq1_payload = p1;
        bus.rsp_ready   = rdy;
        cnt_clr         = clr;
    endtask

    task automatic model_reset();
        m_prio = 0; m_valid = 0; m_src = 0; m_op = 0;
        m_code = 0; m_data = 0; m_syn = 0; m_err = 0; m_cnt = 0;
    endtask

    // One cycle: inputs already driven at the falling edge.
    task automatic step();
        int         win;
        bit         free;
        logic [6:0] pl;
        logic [6:0] cw;
        logic [3:0] dd;
        logic [2:0] ss;
        #2;
        free = !m_valid || bus.rsp_ready;
        win  = -1;
        if (free) begin
            if (bus.rq0_valid && bus.rq1_valid) win = int'(m_prio);
            else if (bus.rq0_valid)             win = 0;
            else if (bus.rq1_valid)             win = 1;
        end
        chk("rq0_ready", bus.rq0_ready, (win == 0));
        chk("rq1_ready", bus.rq1_ready, (win == 1));
        if (win >= 0) begin
            m_src = (win == 1);
            m_op  = m_src ? bus.rq1_op : bus.rq0_op;
            pl    = m_src ? bus.rq1_payload : bus.rq0_payload;
            if (m_op) begin
                decode(pl, cw, dd, ss);
                m_code = cw; m_data = dd; m_syn = ss; m_err = (ss != 0);
            end else begin
                m_code = enc(pl[3:0]); m_data = pl[3:0]; m_syn = 0; m_err = 0;
            end
            m_valid = 1;
            m_prio  = !m_src;
        end else if (bus.rsp_ready) begin
            m_valid = 0;
        end
        if (cnt_clr) m_cnt = 0;
        else if (win >= 0 && m_op && m_err && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        @(posedge clk);
        #1;
        chk("rsp_valid", bus.rsp_valid, m_valid);
        if (m_valid) begin
            chk("rsp_src", bus.rsp_src, m_src);
            chk("rsp_op", bus.rsp_op, m_op);
            chk("rsp_code", bus.rsp_code, m_code);
            chk("rsp_data", bus.rsp_data, m_data);
            chk("rsp_syndrome", bus.rsp_syndrome, m_syn);
            chk("rsp_err", bus.rsp_err, m_err);
        end
        chk("corr_cnt", corr_cnt, m_cnt);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, bus.rsp_valid, 0);
        chk({tag, "_src"}, bus.rsp_src, 0);
        chk({tag, "_op"}, bus.rsp_op, 0);
        chk({tag, "_code"}, bus.rsp_code, 0);
        chk({tag, "_data"}, bus.rsp_data, 0);
        chk({tag, "_syn"}, bus.rsp_syndrome, 0);
        chk({tag, "_err"}, bus.rsp_err, 0);
        chk({tag, "_cnt"}, corr_cnt, 0);
        chk({tag, "_rdy0"}, bus.rq0_ready, 0);
        chk({tag, "_rdy1"}, bus.rq1_ready, 0);
    endtask

    initial begin
        logic [6:0] cw;
        logic [6:0] flip;
        model_reset();
        drive(1, 0, 7'h0B, 1, 1, 7'h51, 1, 0);
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed encodes from rq0
        drive(1, 0, 7'h0B, 0, 0, 0, 1, 0); step();
        chk("enc_0B_code", bus.rsp_code, 7'h55);
        chk("enc_0B_data", bus.rsp_data, 4'hB);
        drive(1, 0, 7'h0F, 0, 0, 0, 1, 0); step();
        chk("enc_0F_code", bus.rsp_code, 7'h7F);
        drive(1, 0, 7'h70, 0, 0, 0, 1, 0); step();
        chk("enc_00_code", bus.rsp_code, 7'h00);

        // Check with correction from rq1
        drive(0, 0, 0, 1, 1, 7'h51, 1, 0); step();
        chk("chk51_syn", bus.rsp_syndrome, 3'd5);
        chk("chk51_err", bus.rsp_err, 1);
        chk("chk51_code", bus.rsp_code, 7'h55);
        chk("chk51_data", bus.rsp_data, 4'hB);
        chk("chk51_src", bus.rsp_src, 1);
        chk("chk51_cnt", corr_cnt, 1);

        // All single-bit flips of 0x55
        for (int i = 0; i < 7; i++) begin
            flip = 7'h55 ^ (7'd1 << i);
            drive(0, 0, 0, 1, 1, flip, 1, 0); step();
            chk("sweep_code", bus.rsp_code, 7'h55);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0); step();

        // Contention
        for (int i = 0; i < 8; i++) begin
            drive(1, $urandom_range(0, 1), 7'($urandom), 1, $urandom_range(0, 1), 7'($urandom), 1, 0);
            step();
        end

        // Back-pressure then pass-through
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 7'($urandom), 1, 0, 7'($urandom), 0, 0);
            step();
        end
        drive(1, 0, 7'h03, 1, 1, 7'h2A, 1, 0); step();
        chk("passthru_valid", bus.rsp_valid, 1);

        // Counter saturation
        drive(0, 0, 0, 0, 0, 0, 1, 1); step();
        for (int i = 0; i < 17; i++) begin
            cw = enc(4'($urandom));
            drive(1, 1, cw ^ (7'd1 << $urandom_range(0, 6)), 0, 0, 0, 1, 0);
            step();
        end
        chk("cnt_saturated", corr_cnt, 4'hF);
        drive(1, 1, 7'h51, 0, 0, 0, 1, 1); step();
        chk("cnt_clr_wins", corr_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 7'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1), 7'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            step();
        end

        // Reset mid-stream
        drive(1, 1, 7'h51, 0, 0, 0, 0, 0); step();
        chk("pre_reset_valid", bus.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 7'h05, 1, 0, 7'h0A, 1, 0);
        #1;
        chk("first_grant_rq0", bus.rq0_ready, 1);
        #1;
        step();
        drive(1, 0, 7'h05, 1, 0, 7'h0A, 1, 0); step();
        chk("second_grant_src", bus.rsp_src, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
